// File: rtl/pipe_mon_pkg.sv
// Shared types and constants for the PIPE handshake monitor.
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    EvtRate      = 2'b00,
    EvtPowerdown = 2'b01,
    EvtDetect    = 2'b10
  } evt_type_e;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitPhy = 1'b1
  } state_e;

  localparam logic [2:0] RXSTAT_OK         = 3'b000;
  localparam logic [2:0] RXSTAT_SKP_ADD    = 3'b001;
  localparam logic [2:0] RXSTAT_SKP_REM    = 3'b010;
  localparam logic [2:0] RXSTAT_DETECTED   = 3'b011;
  localparam logic [2:0] RXSTAT_DECODE_ERR = 3'b100;
  localparam logic [2:0] RXSTAT_OVERFLOW   = 3'b101;
  localparam logic [2:0] RXSTAT_UNDERFLOW  = 3'b110;
  localparam logic [2:0] RXSTAT_DISPARITY  = 3'b111;

endpackage

// File: rtl/pipe_handshake_monitor_if.sv
// PIPE transmit/control bus plus monitor capture and event outputs.
interface pipe_handshake_monitor_if
  import pipe_mon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned KW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]    tx_data;
  logic [KW-1:0]            tx_data_k;
  logic                     tx_data_valid;
  logic                     tx_elec_idle;
  logic                     tx_detect_rx;
  logic [3:0]               rate;
  logic [3:0]               powerdown;
  logic                     phy_status;
  logic [2:0]               rx_status;
  logic [DATA_WIDTH+KW-1:0] mon_data;
  logic                     mon_valid;
  logic                     mon_ready;
  logic                     evt_valid;
  evt_type_e                evt_type;
  logic [2:0]               evt_status;

  modport slave (
    input  tx_data, tx_data_k, tx_data_valid, tx_elec_idle, tx_detect_rx,
    input  rate, powerdown, phy_status, rx_status, mon_ready,
    output mon_data, mon_valid, evt_valid, evt_type, evt_status
  );

  modport master (
    output tx_data, tx_data_k, tx_data_valid, tx_elec_idle, tx_detect_rx,
    output rate, powerdown, phy_status, rx_status, mon_ready,
    input  mon_data, mon_valid, evt_valid, evt_type, evt_status
  );
endinterface

// File: rtl/pipe_mon_fifo.sv
// Capture FIFO: registered storage, wrap-bit pointers, accepts push on full when popping.
module pipe_mon_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop, push_ok;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    valid_o = ~empty_o;
    pop     = valid_o & ready_i;
    push_ok = push_i & (~full_o | pop);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    // Empty head reads as zero so nothing stale leaks out.
    data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/pipe_handshake_monitor.sv
// Monitors PIPE Tx traffic into a capture FIFO and tracks Rate/Powerdown/Detect
// handshakes against PhyStatus, flagging timeouts, spurious and overlapping requests.
module pipe_handshake_monitor
  import pipe_mon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipe_handshake_monitor_if.slave  bus,
  input  logic                     clear_errors_i,
  output logic                     err_timeout_o,
  output logic                     err_spurious_o,
  output logic                     err_overlap_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_count_o
);
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned MW = DATA_WIDTH + KW;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fifo_push, fifo_full, fifo_empty, fifo_valid, drop;

  assign fifo_push     = bus.tx_data_valid & ~bus.tx_elec_idle;
  assign drop          = fifo_push & fifo_full & ~(fifo_valid & bus.mon_ready);
  assign bus.mon_valid = fifo_valid;

  pipe_mon_fifo #(
    .WIDTH (MW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  ({bus.tx_data_k, bus.tx_data}),
    .data_o  (bus.mon_data),
    .valid_o (fifo_valid),
    .ready_i (bus.mon_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  fifo_flags_a: assert property (@(posedge clk) disable iff (!rst_n) fifo_empty == ~fifo_valid);

  // Request detection against last-cycle control values.
  logic       primed_q, last_det_q;
  logic [3:0] last_rate_q, last_pd_q;
  logic       req_valid;
  evt_type_e  req_type;

  always_comb begin
    req_valid = 1'b0;
    req_type  = EvtRate;
    if (primed_q) begin
      if (bus.rate != last_rate_q) begin
        req_valid = 1'b1;
        req_type  = EvtRate;
      end else if (bus.powerdown != last_pd_q) begin
        req_valid = 1'b1;
        req_type  = EvtPowerdown;
      end else if (bus.tx_detect_rx && !last_det_q) begin
        req_valid = 1'b1;
        req_type  = EvtDetect;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q    <= 1'b0;
      last_rate_q <= '0;
      last_pd_q   <= '0;
      last_det_q  <= 1'b0;
    end else begin
      primed_q    <= 1'b1;
      last_rate_q <= bus.rate;
      last_pd_q   <= bus.powerdown;
      last_det_q  <= bus.tx_detect_rx;
    end
  end

  // Handshake FSM.
  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  evt_type_e       type_q, type_d;
  logic            evt_valid_q, evt_valid_d;
  evt_type_e       evt_type_q, evt_type_d;
  logic [2:0]      evt_status_q, evt_status_d;
  logic            set_timeout, set_spurious, set_overlap;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    type_d       = type_q;
    evt_valid_d  = 1'b0;
    evt_type_d   = evt_type_q;
    evt_status_d = evt_status_q;
    set_timeout  = 1'b0;
    set_spurious = 1'b0;
    set_overlap  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StWaitPhy;
          type_d  = req_type;
          timer_d = '0;
        end else if (bus.phy_status) begin
          set_spurious = 1'b1;
        end
      end
      StWaitPhy: begin
        set_overlap = req_valid;
        // Completion takes precedence over a coincident timeout.
        if (bus.phy_status) begin
          evt_valid_d  = 1'b1;
          evt_type_d   = type_q;
          evt_status_d = bus.rx_status;
          state_d      = StIdle;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          set_timeout = 1'b1;
          state_d     = StIdle;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags: a new error in the clearing cycle wins.
  logic        err_timeout_q, err_spurious_q, err_overlap_q, overflow_q;
  logic [15:0] drop_q, drop_d, drop_base;

  always_comb begin
    drop_base = clear_errors_i ? 16'd0 : drop_q;
    drop_d    = (drop && drop_base != 16'hFFFF) ? drop_base + 16'd1 : drop_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      type_q         <= EvtRate;
      evt_valid_q    <= 1'b0;
      evt_type_q     <= EvtRate;
      evt_status_q   <= '0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      err_overlap_q  <= 1'b0;
      overflow_q     <= 1'b0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      type_q         <= type_d;
      evt_valid_q    <= evt_valid_d;
      evt_type_q     <= evt_type_d;
      evt_status_q   <= evt_status_d;
      err_timeout_q  <= set_timeout | (err_timeout_q & ~clear_errors_i);
      err_spurious_q <= set_spurious | (err_spurious_q & ~clear_errors_i);
      err_overlap_q  <= set_overlap | (err_overlap_q & ~clear_errors_i);
      overflow_q     <= drop | (overflow_q & ~clear_errors_i);
      drop_q         <= drop_d;
    end
  end

  assign bus.evt_valid  = evt_valid_q;
  assign bus.evt_type   = evt_type_q;
  assign bus.evt_status = evt_status_q;
  assign err_timeout_o  = err_timeout_q;
  assign err_spurious_o = err_spurious_q;
  assign err_overlap_o  = err_overlap_q;
  assign overflow_o     = overflow_q;
  assign drop_count_o   = drop_q;
endmodule

// File: tb/tb_pipe_handshake_monitor.sv
// Scoreboard bench: stimulus pushes expected words/events, monitors pop and compare.
module tb_pipe_handshake_monitor;
  import pipe_mon_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned MW    = DW + DW / 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] tx_data = '0;
  logic [1:0]  tx_k = '0;
  logic        tx_valid = 1'b0, tx_idle = 1'b0, tx_det = 1'b0;
  logic [3:0]  rate = '0, pd = '0;
  logic        phy = 1'b0, ready = 1'b0, clear_errors = 1'b0;
  logic [2:0]  rxs = '0;

  logic        to16, sp16, ov16, of16, to8, sp8, ov8, of8;
  logic [15:0] dc16, dc8;

  pipe_handshake_monitor_if #(.DATA_WIDTH(16)) bus16 ();
  pipe_handshake_monitor_if #(.DATA_WIDTH(8))  bus8 ();

  assign bus16.tx_data       = tx_data;
  assign bus16.tx_data_k     = tx_k;
  assign bus8.tx_data        = tx_data[7:0];
  assign bus8.tx_data_k      = tx_k[0];
  assign bus16.tx_data_valid = tx_valid;
  assign bus8.tx_data_valid  = tx_valid;
  assign bus16.tx_elec_idle  = tx_idle;
  assign bus8.tx_elec_idle   = tx_idle;
  assign bus16.tx_detect_rx  = tx_det;
  assign bus8.tx_detect_rx   = tx_det;
  assign bus16.rate          = rate;
  assign bus8.rate           = rate;
  assign bus16.powerdown     = pd;
  assign bus8.powerdown      = pd;
  assign bus16.phy_status    = phy;
  assign bus8.phy_status     = phy;
  assign bus16.rx_status     = rxs;
  assign bus8.rx_status      = rxs;
  assign bus16.mon_ready     = ready;
  assign bus8.mon_ready      = ready;

  pipe_handshake_monitor #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .clear_errors_i(clear_errors),
    .err_timeout_o(to16), .err_spurious_o(sp16), .err_overlap_o(ov16),
    .overflow_o(of16), .drop_count_o(dc16)
  );

  pipe_handshake_monitor #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .clear_errors_i(clear_errors),
    .err_timeout_o(to8), .err_spurious_o(sp8), .err_overlap_o(ov8),
    .overflow_o(of8), .drop_count_o(dc8)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [MW-1:0] exp16[$];
  logic [8:0]    exp8[$];
  logic [4:0]    exp_evt[$];
  bit            primed, prev_det, busy;
  logic [3:0]    prev_rate, prev_pd;
  int            ptype, waited;
  bit            m_to, m_sp, m_ov, m_of;
  int            m_drop;

  task automatic model_reset();
    exp16.delete(); exp8.delete(); exp_evt.delete();
    primed = 0; busy = 0; waited = 0; ptype = 0;
    m_to = 0; m_sp = 0; m_ov = 0; m_of = 0; m_drop = 0;
  endtask

  // Evaluate the current inputs, advance one clock, commit expectations.
  task automatic step();
    bit pop, push, acc, drop, evt, e_to, e_sp, e_ov;
    logic [MW-1:0] w;
    logic [4:0] ev;
    int req;
    e_to = 0; e_sp = 0; e_ov = 0; evt = 0; ev = '0;
    pop  = (exp16.size() > 0) && ready;
    push = tx_valid && !tx_idle;
    acc  = push && (exp16.size() < DEPTH || pop);
    drop = push && !acc;
    w    = {tx_k, tx_data};
    req  = -1;
    if (primed) begin
      if (rate != prev_rate)          req = 0;
      else if (pd != prev_pd)         req = 1;
      else if (tx_det && !prev_det)   req = 2;
    end
    primed = 1; prev_rate = rate; prev_pd = pd; prev_det = tx_det;
    if (busy) begin
      if (req >= 0) e_ov = 1;
      if (phy) begin
        evt = 1; ev = {2'(ptype), rxs}; busy = 0;
      end else if (waited + 1 == int'(TO)) begin
        e_to = 1; busy = 0;
      end else begin
        waited++;
      end
    end else if (req >= 0) begin
      busy = 1; ptype = req; waited = 0;
    end else if (phy) begin
      e_sp = 1;
    end
    @(posedge clk);
    if (acc) begin
      exp16.push_back(w);
      exp8.push_back({w[16], w[7:0]});
    end
    if (evt) exp_evt.push_back(ev);
    m_to = e_to || (m_to && !clear_errors);
    m_sp = e_sp || (m_sp && !clear_errors);
    m_ov = e_ov || (m_ov && !clear_errors);
    m_of = drop || (m_of && !clear_errors);
    if (clear_errors) m_drop = 0;
    if (drop && m_drop < 65535) m_drop++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, " err_timeout"},  {31'd0, to16}, {31'd0, m_to});
    chk({tag, " err_spurious"}, {31'd0, sp16}, {31'd0, m_sp});
    chk({tag, " err_overlap"},  {31'd0, ov16}, {31'd0, m_ov});
    chk({tag, " overflow"},     {31'd0, of16}, {31'd0, m_of});
    chk({tag, " drop_count"},   {16'd0, dc16}, m_drop);
    chk({tag, " overflow8"},    {31'd0, of8},  {31'd0, m_of});
    chk({tag, " drop_count8"},  {16'd0, dc8},  m_drop);
  endtask

  // Output monitor
  always @(negedge clk) begin
    logic [MW-1:0] w;
    logic [8:0]    w8;
    logic [4:0]    e;
    if (rst_n) begin
      chk("mon_valid16", {31'd0, bus16.mon_valid}, {31'd0, exp16.size() != 0});
      chk("mon_valid8",  {31'd0, bus8.mon_valid},  {31'd0, exp8.size() != 0});
      if (bus16.mon_valid && bus16.mon_ready && exp16.size() != 0) begin
        w = exp16.pop_front();
        chk("mon_data16", {14'd0, bus16.mon_data}, {14'd0, w});
      end
      if (bus8.mon_valid && bus8.mon_ready && exp8.size() != 0) begin
        w8 = exp8.pop_front();
        chk("mon_data8", {23'd0, bus8.mon_data}, {23'd0, w8});
      end
      if (bus16.evt_valid) begin
        if (exp_evt.size() == 0) begin
          chk("evt_valid_extra", {31'd0, bus16.evt_valid}, 32'd0);
        end else begin
          e = exp_evt.pop_front();
          chk("evt_type",   {30'd0, bus16.evt_type},   {30'd0, e[4:3]});
          chk("evt_status", {29'd0, bus16.evt_status}, {29'd0, e[2:0]});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst mon_valid",  {31'd0, bus16.mon_valid}, 32'd0);
    chk("rst mon_data",   {14'd0, bus16.mon_data}, 32'd0);
    chk("rst mon_data8",  {23'd0, bus8.mon_data}, 32'd0);
    chk("rst evt_valid",  {31'd0, bus16.evt_valid}, 32'd0);
    chk("rst evt_type",   {30'd0, bus16.evt_type}, 32'd0);
    chk("rst evt_status", {29'd0, bus16.evt_status}, 32'd0);
    check_flags("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    steps(2);

    // Overflow: 20 pushes with no pop.
    ready = 0; tx_valid = 1; tx_idle = 0;
    for (int i = 0; i < 20; i++) begin
      tx_data = 16'($urandom()); tx_k = 2'($urandom()); step();
    end
    tx_valid = 0;
    step();
    chk("ovf drop_count==4", {16'd0, dc16}, 32'd4);
    chk("ovf overflow==1", {31'd0, of16}, 32'd1);
    check_flags("ovf");
    ready = 1; steps(18);
    chk("ovf drained", {31'd0, bus16.mon_valid}, 32'd0);
    clear_errors = 1; step(); clear_errors = 0; step();
    check_flags("clr1");

    // Full FIFO with simultaneous push/pop.
    ready = 0; tx_valid = 1;
    for (int i = 0; i < 16; i++) begin
      tx_data = 16'($urandom()); tx_k = 2'($urandom()); step();
    end
    ready = 1;
    for (int i = 0; i < 12; i++) begin
      tx_data = 16'($urandom()); tx_k = 2'($urandom()); step();
    end
    tx_valid = 0;
    check_flags("fullpp");
    steps(20);

    // Rate change, PhyStatus after 5 cycles.
    rate = 4'd1; step();
    steps(5);
    phy = 1; rxs = RXSTAT_OK; step(); phy = 0;
    steps(3);
    chk("rate evt consumed", exp_evt.size(), 32'd0);
    check_flags("rate");

    // Receiver detect.
    tx_det = 1; step();
    steps(3);
    phy = 1; rxs = RXSTAT_DETECTED; step(); phy = 0; tx_det = 0;
    steps(3);
    chk("detect evt consumed", exp_evt.size(), 32'd0);
    check_flags("detect");

    // Powerdown timeout.
    pd = 4'd2; step();
    steps(63);
    chk("timeout early", {31'd0, to16}, 32'd0);
    step();
    chk("timeout at 64", {31'd0, to16}, 32'd1);
    steps(2);
    check_flags("timeout");
    clear_errors = 1; step(); clear_errors = 0;

    // Overlap, spurious, clear.
    rate = 4'd2; step(); steps(2);
    pd = 4'd5; step();
    phy = 1; rxs = RXSTAT_SKP_ADD; step(); phy = 0;
    steps(2);
    phy = 1; step(); phy = 0;
    step();
    chk("overlap set", {31'd0, ov16}, 32'd1);
    chk("spurious set", {31'd0, sp16}, 32'd1);
    check_flags("ovlp");
    clear_errors = 1; step(); clear_errors = 0; step();
    check_flags("clr2");

    // Reset mid-handshake.
    rate = 4'd3; step(); steps(2);
    do_reset();
    steps(4);
    phy = 0; steps(70);
    check_flags("midrst");

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_idle  = ($urandom_range(0, 7) == 0);
      tx_data  = 16'($urandom());
      tx_k     = 2'($urandom());
      ready    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rate = 4'($urandom());
      if ($urandom_range(0, 39) == 0) pd = 4'($urandom());
      if ($urandom_range(0, 19) == 0) tx_det = ~tx_det;
      phy          = ($urandom_range(0, 11) == 0);
      rxs          = 3'($urandom());
      clear_errors = ($urandom_range(0, 99) == 0);
      step();
      if (i % 100 == 99) check_flags("rand");
    end
    tx_valid = 0; phy = 0; clear_errors = 0; ready = 1;
    steps(80);
    chk("final fifo16 empty", exp16.size(), 32'd0);
    chk("final fifo8 empty", exp8.size(), 32'd0);
    chk("final evt empty", exp_evt.size(), 32'd0);
    check_flags("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
